// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
//   Shared types and helpers for the iterative RV32M multiply/divide unit.
//   - XLEN        : operand/result width (only 32 is supported)
//   - md_op_t     : funct3 encoding of the eight M-extension ops
//   - md_state_t  : sequencer states
//   - helpers     : operand signedness decode and magnitude extraction
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    // MUL keeps both operands unsigned: its low word is sign-agnostic.
    function automatic logic src1_signed(input md_op_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic src2_signed(input md_op_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic is_div_op(input md_op_t op);
        return op[2];
    endfunction

    // |0x80000000| stays 0x80000000, which is exact when read as unsigned.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Request/response handshake between the EX stage and the mul/div unit.
//   Request : req_valid, req_ready, req_op (funct3), req_src1, req_src2
//   Response: resp_valid, resp_ready, resp_result
//   master = EX stage side, slave = mul/div unit side.
// -----------------------------------------------------------------------------
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic            req_valid;
    logic            req_ready;
    md_op_t          req_op;
    logic [XLEN-1:0] req_src1;
    logic [XLEN-1:0] req_src2;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;

    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_result
    );

endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
//   One 33-bit add (multiply) or subtract (restoring divide) step per cycle
//   over 32 iterations on operand magnitudes, then a sign fix-up.
//
//   Ports
//     clk    in   clock, all state on rising edge
//     rst    in   synchronous active-high reset
//     flush  in   pipeline kill, aborts any op in flight (no response issued)
//     busy   out  high in every state except IDLE (EX stall)
//     bus    slave modport of muldiv_unit_if (request/response handshake)
//
//   Timing: accept at edge k -> resp_valid from edge k+34 (32 CALC edges,
//   one FIX edge, then resp_valid rises on the first edge spent in DONE).
//   A divide by zero goes straight to DONE, so resp_valid rises at k+1.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    output logic            busy,
    muldiv_unit_if.slave    bus
);

    md_state_t       state;
    md_op_t          op;
    logic [4:0]      cnt;
    logic            neg_res;
    // acc is the multiply high word / divide partial remainder;
    // lo is the multiply low word (multiplier shifts out) / divide quotient.
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opb;        // |src2|: multiplicand or divisor
    logic            resp_valid;
    logic [XLEN-1:0] resp_result;

    // Request decode used at the accept edge.
    logic            in_neg1;
    logic            in_neg2;
    logic            in_div_zero;

    // Datapath step and fix-up results.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   fix_result;

    assign bus.req_ready   = (state == MD_IDLE) & ~rst & ~flush;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_result = resp_result;
    assign busy            = (state != MD_IDLE);

    assign in_neg1     = src1_signed(bus.req_op) & bus.req_src1[XLEN-1];
    assign in_neg2     = src2_signed(bus.req_op) & bus.req_src2[XLEN-1];
    assign in_div_zero = is_div_op(bus.req_op) & (bus.req_src2 == '0);

    // Multiply: add the multiplicand into the high word when the current
    // multiplier bit is set; the carry becomes bit 63 after the shift.
    assign mul_sum   = {1'b0, acc[XLEN-1:0]} + {1'b0, (lo[0] ? opb : '0)};
    // Divide: shift in the next dividend bit and trial-subtract the divisor.
    // The remainder is always below the divisor, so bit 32 is the sign.
    assign div_trial = {acc[XLEN-1:0], lo[XLEN-1]} - {1'b0, opb};
    assign prod_neg  = ~{acc[XLEN-1:0], lo} + 1'b1;

    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fix_result = lo;
        unique case (op)
            MD_MUL:                      fix_result = neg_res ? prod_neg[XLEN-1:0] : lo;
            MD_MULH, MD_MULHSU, MD_MULHU: fix_result = neg_res ? prod_neg[2*XLEN-1:XLEN]
                                                               : acc[XLEN-1:0];
            MD_DIV, MD_DIVU:             fix_result = neg_res ? (~lo + 1'b1) : lo;
            MD_REM, MD_REMU:             fix_result = neg_res ? (~acc[XLEN-1:0] + 1'b1)
                                                              : acc[XLEN-1:0];
            default:                     fix_result = lo;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values regardless of order.
    // NOTE: only control state and the visible outputs are reset; the
    // datapath registers (op, acc, lo, opb, neg_res) are always loaded at
    // accept before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MD_IDLE;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            cnt         <= '0;
        end else if (flush) begin
            // Kill beats both accept and response completion.
            state      <= MD_IDLE;
            resp_valid <= 1'b0;
            cnt        <= '0;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    // req_ready is implied here: IDLE, not rst, not flush.
                    if (bus.req_valid) begin
                        op      <= bus.req_op;
                        // REM takes the dividend's sign; all else the XOR.
                        neg_res <= (bus.req_op == MD_REM) ? in_neg1 : (in_neg1 ^ in_neg2);
                        acc     <= '0;
                        lo      <= magnitude(bus.req_src1, in_neg1);
                        opb     <= magnitude(bus.req_src2, in_neg2);
                        cnt     <= '0;
                        if (in_div_zero) begin
                            // funct3[1] picks REM*/REMU (dividend) over DIV*/DIVU (all ones).
                            resp_result <= bus.req_op[1] ? bus.req_src1 : '1;
                            state       <= MD_DONE;
                        end else begin
                            state <= MD_CALC;
                        end
                    end
                end

                MD_CALC: begin
                    if (is_div_op(op)) begin
                        if (!div_trial[XLEN]) begin
                            acc <= div_trial;
                            lo  <= {lo[XLEN-2:0], 1'b1};
                        end else begin
                            acc <= {acc[XLEN-1:0], lo[XLEN-1]};
                            lo  <= {lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {1'b0, mul_sum[XLEN:1]};
                        lo  <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= MD_FIX;
                    end
                end

                MD_FIX: begin
                    resp_result <= fix_result;
                    state       <= MD_DONE;
                end

                MD_DONE: begin
                    // resp_result is already stable when resp_valid rises.
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (bus.resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= MD_IDLE;
                    end
                end

                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule
